// File: rtl/ysyx_23060075_axi_sram.sv
// AXI4-Lite slave in front of a word-addressed SRAM array. Serves one
// transaction at a time and inserts a per-transaction response delay, either
// fixed or taken from a 4-bit LFSR, to model variable memory latency.
module ysyx_23060075_axi_sram #(
  parameter int                    ISA_WIDTH      = 32,
  parameter int                    MEM_MASK_WIDTH = 4,
  parameter int                    ADDR_BITS      = 10,
  parameter logic [ISA_WIDTH-1:0]  BASE_ADDR      = 32'h8000_0000,
  parameter bit                    RAND_DELAY     = 1'b1,
  parameter int                    FIXED_DELAY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ISA_WIDTH-1:0]      araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [ISA_WIDTH-1:0]      rdata,
  output logic [ISA_WIDTH-1:0]      rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [ISA_WIDTH-1:0]      awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ISA_WIDTH-1:0]      wdata,
  input  logic [MEM_MASK_WIDTH-1:0] wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ISA_WIDTH-1:0]      bresp,
  output logic                      bvalid,
  input  logic                      bready
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ISA_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [ISA_WIDTH-1:0] RESP_SLVERR = ISA_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, R_DLY, R_RSP, W_DLY, W_RSP} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                cnt;
  logic [3:0]                lfsr;
  logic [2:0]                delay;
  logic [ADDR_BITS-1:0]      idx;
  logic                      err;
  logic [ISA_WIDTH-1:0]      wdata_q;
  logic [MEM_MASK_WIDTH-1:0] wstrb_q;
  logic [ISA_WIDTH-1:0]      mem [DEPTH];
  logic [ISA_WIDTH-1:0]      ar_off, aw_off;
  logic                      ar_fire, aw_fire, commit;
  logic                      unused_addr_lsbs;

  // Offsets from the window base; anything above the array span (including
  // addresses below the base, which wrap to large values) is out of range.
  assign ar_off  = araddr - BASE_ADDR;
  assign aw_off  = awaddr - BASE_ADDR;
  // Byte offset within a word plays no part in word-wide accesses.
  assign unused_addr_lsbs = ^{ar_off[1:0], aw_off[1:0]};

  assign delay   = RAND_DELAY ? lfsr[2:0] : 3'(FIXED_DELAY);
  assign ar_fire = arvalid && arready;
  assign aw_fire = awready;
  assign commit  = (state == W_DLY) && (cnt == 3'd0) && !err;

  // Next state and handshake outputs; readies are forced low while in reset.
  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    bvalid    = 1'b0;
    case (state)
      IDLE: begin
        arready = rst;
        awready = rst && awvalid && wvalid && !arvalid;
        wready  = awready;
        if (ar_fire)      state_nxt = R_DLY;
        else if (aw_fire) state_nxt = W_DLY;
      end
      R_DLY: if (cnt == 3'd0) state_nxt = R_RSP;
      R_RSP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = IDLE;
      end
      W_DLY: if (cnt == 3'd0) state_nxt = W_RSP;
      W_RSP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Delay counter, LFSR and registered responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 3'd0;
      lfsr  <= 4'b1001;
      rdata <= '0;
      rresp <= '0;
      bresp <= '0;
    end else begin
      case (state)
        IDLE: if (ar_fire || aw_fire) begin
          cnt  <= delay;
          lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
        R_DLY: if (cnt == 3'd0) begin
          rdata <= err ? '0 : mem[idx];
          rresp <= err ? RESP_SLVERR : RESP_OKAY;
        end else begin
          cnt <= cnt - 3'd1;
        end
        W_DLY: if (cnt == 3'd0) bresp <= err ? RESP_SLVERR : RESP_OKAY;
               else cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Request capture at accept time; payload needs no reset.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      idx <= ar_off[ADDR_BITS+1:2];
      err <= |ar_off[ISA_WIDTH-1:ADDR_BITS+2];
    end else if (aw_fire) begin
      idx     <= aw_off[ADDR_BITS+1:2];
      err     <= |aw_off[ISA_WIDTH-1:ADDR_BITS+2];
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Byte-masked array write, committed as the write leaves its delay phase.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < MEM_MASK_WIDTH; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060075_axi_sram.sv
// Directed bench: instance 0 uses a fixed zero delay, instance 1 the LFSR delay.
module tb_ysyx_23060075_axi_sram;

  logic        clk, rst;
  logic [31:0] araddr [2], rdata [2], rresp [2], awaddr [2], wdata [2], bresp [2];
  logic        arvalid [2], arready [2], rvalid [2], rready [2];
  logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic [3:0]  wstrb [2];
  int          errors = 0;
  int          checks = 0;

  ysyx_23060075_axi_sram #(.RAND_DELAY(1'b0), .FIXED_DELAY(0)) dut0 (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_23060075_axi_sram #(.RAND_DELAY(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full read transaction; lat = clock edges from address accept to rvalid.
  task automatic do_read(input int k, input logic [31:0] a,
                         output logic [31:0] d, output logic [31:0] r, output int lat);
    int n = 0;
    @(posedge clk); #1;
    araddr[k] = a; arvalid[k] = 1'b1; rready[k] = 1'b1; #1;
    while (!arready[k] && n < 50) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
    lat = 0;
    while (!rvalid[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (n >= 50 || lat >= 50) begin
      errors++; $display("FAIL read_timeout: addr %h arready_wait=%0d rvalid_wait=%0d limit 50", a, n, lat);
    end
    d = rdata[k]; r = rresp[k];
    @(posedge clk); #1;
    rready[k] = 1'b0;
  endtask

  // Full write transaction; lat = clock edges from accept to bvalid.
  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r, output int lat);
    int n = 0;
    @(posedge clk); #1;
    awaddr[k] = a; wdata[k] = d; wstrb[k] = s;
    awvalid[k] = 1'b1; wvalid[k] = 1'b1; bready[k] = 1'b1; #1;
    while (!awready[k] && n < 50) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    awvalid[k] = 1'b0; wvalid[k] = 1'b0;
    lat = 0;
    while (!bvalid[k] && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (n >= 50 || lat >= 50) begin
      errors++; $display("FAIL write_timeout: addr %h awready_wait=%0d bvalid_wait=%0d limit 50", a, n, lat);
    end
    r = bresp[k];
    @(posedge clk); #1;
    bready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; #2; rst = 1'b0;
    repeat (3) @(posedge clk); #2;
    checks++; if (arready[0] !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", arready[0]); end
    checks++; if (awready[0] !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b want 0", awready[0]); end
    checks++; if (wready[0]  !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", wready[0]); end
    checks++; if (rvalid[0]  !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid[0]); end
    checks++; if (bvalid[0]  !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bvalid[0]); end
    checks++; if (rdata[0]   !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata[0]); end
    checks++; if (rresp[0]   !== 32'h0) begin errors++; $display("FAIL rst_rresp: got %h want 0", rresp[0]); end
    checks++; if (bresp[0]   !== 32'h0) begin errors++; $display("FAIL rst_bresp: got %h want 0", bresp[0]); end
    #3; rst = 1'b1;
    @(posedge clk); #2;
    checks++; if (arready[0] !== 1'b1) begin errors++; $display("FAIL idle_arready: got %b want 1", arready[0]); end
    checks++; if (awready[0] !== 1'b0) begin errors++; $display("FAIL idle_awready_novalid: got %b want 0", awready[0]); end
  endtask

  task automatic test_basic;
    logic [31:0] d, r; int lat;
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wlat: got %0d want 1", lat); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL basic_bresp: got %h want 0", r); end
    do_read(0, 32'h8000_0010, d, r, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rlat: got %0d want 1", lat); end
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata: got %h want deadbeef", d); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL basic_rresp: got %h want 0", r); end
  endtask

  task automatic test_strobe;
    logic [31:0] d, r; int lat;
    do_write(0, 32'h8000_0020, 32'h1122_3344, 4'hF, r, lat);
    do_write(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r, lat);
    do_read(0, 32'h8000_0020, d, r, lat);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_rdata: got %h want 11bb33dd", d); end
    do_read(0, 32'h8000_0023, d, r, lat);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_lsbs_ignored: got %h want 11bb33dd", d); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL strobe_rresp: got %h want 0", r); end
  endtask

  task automatic test_priority;
    logic [31:0] d, r; int lat;
    @(posedge clk); #1;
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b1;
    awaddr[0] = 32'h8000_0030; wdata[0] = 32'h5555_AAAA; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1; #1;
    checks++; if (arready[0] !== 1'b1) begin errors++; $display("FAIL prio_arready: got %b want 1", arready[0]); end
    checks++; if (awready[0] !== 1'b0) begin errors++; $display("FAIL prio_awready: got %b want 0", awready[0]); end
    checks++; if (wready[0]  !== 1'b0) begin errors++; $display("FAIL prio_wready: got %b want 0", wready[0]); end
    @(posedge clk); #1; arvalid[0] = 1'b0; #1;
    checks++; if (awready[0] !== 1'b0) begin errors++; $display("FAIL prio_awready_busy: got %b want 0", awready[0]); end
    @(posedge clk); #2;
    checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL prio_rvalid: got %b want 1", rvalid[0]); end
    checks++; if (rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_rdata: got %h want deadbeef", rdata[0]); end
    checks++; if (awready[0] !== 1'b0) begin errors++; $display("FAIL prio_awready_rsp: got %b want 0", awready[0]); end
    @(posedge clk); #2;
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL prio_rvalid_drop: got %b want 0", rvalid[0]); end
    checks++; if (awready[0] !== 1'b1) begin errors++; $display("FAIL prio_awready_after: got %b want 1", awready[0]); end
    rready[0] = 1'b0;
    @(posedge clk); #1; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(posedge clk); #2;
    checks++; if (bvalid[0] !== 1'b1 || bresp[0] !== 32'h0) begin
      errors++; $display("FAIL prio_bvalid: got bvalid=%b bresp=%h want 1/0", bvalid[0], bresp[0]);
    end
    @(posedge clk); #1; bready[0] = 1'b0;
    do_read(0, 32'h8000_0030, d, r, lat);
    checks++; if (d !== 32'h5555_AAAA) begin errors++; $display("FAIL prio_write_data: got %h want 5555aaaa", d); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    @(posedge clk); #1;
    araddr[0] = 32'h8000_0020; arvalid[0] = 1'b1; rready[0] = 1'b0;
    @(posedge clk); #1;
    araddr[0] = 32'h8000_0010;
    while (!rvalid[0] && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL bp_rvalid[%0d]: got %b want 1", i, rvalid[0]); end
      checks++; if (rdata[0] !== 32'h11BB_33DD) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want 11bb33dd", i, rdata[0]); end
      checks++; if (rresp[0] !== 32'h0) begin errors++; $display("FAIL bp_rresp[%0d]: got %h want 0", i, rresp[0]); end
      checks++; if (arready[0] !== 1'b0) begin errors++; $display("FAIL bp_arready[%0d]: got %b want 0", i, arready[0]); end
      @(posedge clk); #1;
    end
    arvalid[0] = 1'b0; rready[0] = 1'b1;
    @(posedge clk); #2;
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", rvalid[0]); end
    rready[0] = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] d, r; int lat;
    do_write(0, 32'h8000_0000, 32'h0102_0304, 4'hF, r, lat);
    do_read(0, 32'h0000_0000, d, r, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL oor_low_rresp: got %h want 2", r); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_low_rdata: got %h want 0", d); end
    do_read(0, 32'h7FFF_FFFC, d, r, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL oor_below_rresp: got %h want 2", r); end
    do_write(0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, r, lat);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL oor_bresp: got %h want 2", r); end
    do_read(0, 32'h8000_0000, d, r, lat);
    checks++; if (d !== 32'h0102_0304) begin errors++; $display("FAIL oor_no_alias: got %h want 01020304", d); end
    do_write(0, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, r, lat);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL top_word_bresp: got %h want 0", r); end
    do_read(0, 32'h8000_0FFC, d, r, lat);
    checks++; if (d !== 32'hCAFE_F00D || r !== 32'h0) begin
      errors++; $display("FAIL top_word_read: got %h/%h want cafef00d/0", d, r);
    end
  endtask

  task automatic test_random_delay;
    logic [31:0] d, r; int lat; logic [8:0] seen = '0; int kinds = 0;
    for (int i = 0; i < 8; i++) do_write(1, 32'h8000_0100 + 4*i, 32'hC0DE_0000 + 32'h1111 * i, 4'hF, r, lat);
    for (int i = 0; i < 100; i++) begin
      do_read(1, 32'h8000_0100 + 4*(i % 8), d, r, lat);
      checks++; if (d !== 32'hC0DE_0000 + 32'h1111 * (i % 8)) begin
        errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, d, 32'hC0DE_0000 + 32'h1111 * (i % 8));
      end
      checks++; if (lat < 1 || lat > 8) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 1..8", i, lat); end
      if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
    end
    for (int i = 1; i <= 8; i++) kinds += int'(seen[i]);
    checks++; if (kinds < 2) begin errors++; $display("FAIL rand_latency_varies: got %0d distinct want >=2", kinds); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, r; int lat; int n = 0;
    @(posedge clk); #1;
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b1;
    @(posedge clk); #1; arvalid[0] = 1'b0;
    #1; rst = 1'b0; #1;
    checks++; if (rvalid[0] !== 1'b0 || arready[0] !== 1'b0) begin
      errors++; $display("FAIL rst_dly_async: got rvalid=%b arready=%b want 0/0", rvalid[0], arready[0]);
    end
    repeat (2) @(posedge clk); #1;
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL rst_dly_dropped: got %b want 0", rvalid[0]); end
    #2; rst = 1'b1;
    @(posedge clk); #2;
    checks++; if (arready[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
      errors++; $display("FAIL rst_release: got arready=%b rvalid=%b want 1/0", arready[0], rvalid[0]);
    end
    rready[0] = 1'b0;
    do_read(0, 32'h8000_0010, d, r, lat);
    checks++; if (d !== 32'hDEAD_BEEF || r !== 32'h0) begin
      errors++; $display("FAIL rst_after_read: got %h/%h want deadbeef/0", d, r);
    end
    @(posedge clk); #1;
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1;
    @(posedge clk); #1; arvalid[0] = 1'b0;
    while (!rvalid[0] && n < 50) begin @(posedge clk); #1; n++; end
    #1; rst = 1'b0; #1;
    checks++; if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      errors++; $display("FAIL rst_rsp_async: got rvalid=%b rdata=%h want 0/0", rvalid[0], rdata[0]);
    end
    #2; rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      araddr[k] = '0; arvalid[k] = 1'b0; rready[k] = 1'b0;
      awaddr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
      awvalid[k] = 1'b0; wvalid[k] = 1'b0; bready[k] = 1'b0;
    end
    test_reset;
    test_basic;
    test_strobe;
    test_priority;
    test_backpressure;
    test_out_of_range;
    test_random_delay;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
